sfr_bus_arb: RTL and testbench
==============================

Name: sfr_bus_arb

Overview:
- Two-master arbiter and sequencer for the 8051 SFR bus: wren/rden, 7-bit address (SFR 0x80–0xFF minus 0x80), 8-bit data in, combinational q out.
- Master 0 is the CPU core; master 1 is the debug/monitor port.
- Supported operations: byte read, byte write, and atomic read-modify-write bit operations (SETB/CLR/CPL style).
- Only this block drives the SFR bus strobes.

Parameters:
- ADDR_W, 7, SFR address width.
- DATA_W, 8, SFR data width.
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  master 0 request; held high with fields stable until m0_ack.
- m0_op  input  2  00 read, 01 write, 10 bit-write, 11 bit-toggle.
- m0_addr  input  ADDR_W  SFR address.
- m0_wdata  input  DATA_W  write data; for bit-write only bit 0 is used (new bit value).
- m0_bit  input  3  bit index for bit ops.
- m0_ack  output  1  one-cycle completion pulse.
- m0_rdata  output  DATA_W  read result, valid from m0_ack and held until the next m0_ack.
- m1_req / m1_op / m1_addr / m1_wdata / m1_bit / m1_ack / m1_rdata  same as master 0.
- sfr_wren  output  1  SFR write strobe.
- sfr_rden  output  1  SFR read strobe.
- sfr_address  output  ADDR_W  SFR address.
- sfr_data  output  DATA_W  SFR write data.
- sfr_q  input  DATA_W  SFR read data, combinational on sfr_rden/sfr_address.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, rdata registers 0, round-robin pointer = "master 1 last", so master 0 wins the first tie.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, ACK.
- IDLE:
  - Sample req lines.
  - With no request, stay in IDLE.
  - Otherwise pick the winner; latch its op, addr, wdata and bit; record the grant in the pointer.
  - Next state: RD (op 00), WR (op 01), RMW_RD (op 1x).
- Arbitration:
  - FIXED_PRIO=0: on a tie, grant the master not granted last.
  - FIXED_PRIO=1: master 0 wins every tie.
  - A request is granted only in IDLE; no preemption.
- RD: sfr_rden=1, sfr_address=latched addr for exactly one cycle; sfr_q captured into the winner's rdata at the closing edge. Next state ACK.
- WR: sfr_wren=1, sfr_address and sfr_data driven for one cycle; the SFR captures at the closing edge. Winner's rdata unchanged. Next state ACK.
- RMW_RD: same as RD; sfr_q captured into the winner's rdata and into an internal tmp register. Next state RMW_WR.
- RMW_WR:
  - sfr_wren=1; sfr_data = tmp with bit[m_bit] replaced by wdata[0] (op 10) or inverted (op 11).
  - Other bits pass through unchanged.
  - rdata keeps the pre-modify value. Next state ACK.
- ACK: the winner's ack=1 for one cycle, then IDLE.
  - Requester drops req at the edge where it samples ack.
  - A req still high in IDLE is a new request.
- Latency from req seen in IDLE: read/write ack 2 cycles later; RMW ack 3 cycles later.
- Back-to-back: minimum 3 cycles (read/write) or 4 cycles (RMW) per transaction; each master is served at least every second transaction under FIXED_PRIO=0.
- Bus strobes:
  - sfr_rden and sfr_wren are never high together and are never high in IDLE or ACK.
  - sfr_address and sfr_data are 0 when no strobe is active.
- No address filtering: bit ops are permitted at any address; ops are executed as given.
- Reset mid-operation: strobes drop immediately, no ack is issued, and a pending RMW write is abandoned. The requester must reissue.
- Non-winning master's ack stays 0 and its rdata is untouched throughout.

Test Plan:
- Reset during idle → all outputs 0, busy=0; then m0 read addr 0x10 with sfr_q=0xA5 → sfr_rden high 1 cycle with address 0x10, m0_ack 2 cycles after req, m0_rdata=0xA5.
- m1 write addr 0x20 data 0x3C → one cycle with sfr_wren=1, address 0x20, data 0x3C, no sfr_rden; m1_ack at +2; m1_rdata unchanged.
- m0 bit-write addr 0x00 bit 3 wdata[0]=0, sfr_q=0xFF → read cycle, then write cycle with data 0xF7, ack at +3, m0_rdata=0xFF; bit-toggle bit 7 on 0x0F → write 0x8F.
- Both req continuously, FIXED_PRIO=0 → grants alternate m0, m1, m0, m1; FIXED_PRIO=1 → m0 starves m1 while m0_req is held (re-raised after each ack).
- Assert rst_n low during RMW_RD of a bit op → strobes 0 same cycle, no sfr_wren ever pulses, no ack; after release the first tie goes to m0.
- Assertion bench over random traffic: sfr_rden&sfr_wren never 1; ack only in ACK state; at most one ack per cycle.

Source files
------------

// File: rtl/sfr_bus_arb_if.sv
// SFR bus arbiter bundle: two requesting masters plus the single SFR bus side.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface sfr_bus_arb_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic [1:0]        m0_op;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [2:0]        m0_bit;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [1:0]        m1_op;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [2:0]        m1_bit;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              sfr_wren;
  logic              sfr_rden;
  logic [ADDR_W-1:0] sfr_address;
  logic [DATA_W-1:0] sfr_data;
  logic [DATA_W-1:0] sfr_q;
  logic              busy;

  modport slave (
    input  m0_req, m0_op, m0_addr, m0_wdata, m0_bit,
    input  m1_req, m1_op, m1_addr, m1_wdata, m1_bit,
    input  sfr_q,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output sfr_wren, sfr_rden, sfr_address, sfr_data, busy
  );

  modport master (
    output m0_req, m0_op, m0_addr, m0_wdata, m0_bit,
    output m1_req, m1_op, m1_addr, m1_wdata, m1_bit,
    output sfr_q,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  sfr_wren, sfr_rden, sfr_address, sfr_data, busy
  );
endinterface

// File: rtl/sfr_bus_arb.sv
// Two-master arbiter/sequencer for the 8051 SFR bus: read, write and atomic
// read-modify-write bit set/clear/toggle, one transaction at a time.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// RD     | one-cycle read strobe, capture sfr_q into winner's rdata
// WR     | one-cycle write strobe with latched data
// RMW_RD | read strobe, capture sfr_q into rdata and tmp
// RMW_WR | write strobe with tmp's selected bit replaced or inverted
// ACK    | one-cycle ack to the winner
module sfr_bus_arb #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input logic          clk,
  input logic          rst_n,
  sfr_bus_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, ACK} state_t;

  state_t            r_state, w_next;
  logic              r_gnt, r_last, r_toggle;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_tmp, r_rdata0, r_rdata1;
  logic [2:0]        r_bit;

  logic              w_any, w_pick;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_mod;

  // r_last resets to 1 so master 0 takes the first tie after reset
  always_comb begin
    w_any = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req)
      w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    else
      w_pick = bus.m1_req;
    w_op = w_pick ? bus.m1_op : bus.m0_op;
  end

  always_comb begin
    w_mod = r_tmp;
    if (r_toggle)
      w_mod[r_bit] = ~r_tmp[r_bit];
    else
      w_mod[r_bit] = r_wdata[0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          case (w_op)
            2'b00:   w_next = RD;
            2'b01:   w_next = WR;
            default: w_next = RMW_RD;
          endcase
        end
      end
      RD:      w_next = ACK;
      WR:      w_next = ACK;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.sfr_rden    = 1'b0;
    bus.sfr_wren    = 1'b0;
    bus.sfr_address = '0;
    bus.sfr_data    = '0;
    bus.m0_ack      = 1'b0;
    bus.m1_ack      = 1'b0;
    bus.busy        = (r_state != IDLE);
    case (r_state)
      RD, RMW_RD: begin
        bus.sfr_rden    = 1'b1;
        bus.sfr_address = r_addr;
      end
      WR: begin
        bus.sfr_wren    = 1'b1;
        bus.sfr_address = r_addr;
        bus.sfr_data    = r_wdata;
      end
      RMW_WR: begin
        bus.sfr_wren    = 1'b1;
        bus.sfr_address = r_addr;
        bus.sfr_data    = w_mod;
      end
      ACK: begin
        bus.m0_ack = ~r_gnt;
        bus.m1_ack = r_gnt;
      end
      default: ;
    endcase
  end

  assign bus.m0_rdata = r_rdata0;
  assign bus.m1_rdata = r_rdata1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_toggle <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_bit    <= '0;
      r_tmp    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_gnt    <= w_pick;
        r_last   <= w_pick;
        r_toggle <= w_op[0];
        r_addr   <= w_pick ? bus.m1_addr  : bus.m0_addr;
        r_wdata  <= w_pick ? bus.m1_wdata : bus.m0_wdata;
        r_bit    <= w_pick ? bus.m1_bit   : bus.m0_bit;
      end
      if (r_state == RD || r_state == RMW_RD) begin
        r_tmp <= bus.sfr_q;
        if (r_gnt) r_rdata1 <= bus.sfr_q;
        else       r_rdata0 <= bus.sfr_q;
      end
    end
  end

endmodule

// File: tb/tb_sfr_bus_arb.sv
// Directed bench for sfr_bus_arb: round-robin instance (dut0) and fixed-priority
// instance (dut1); inputs driven and outputs sampled on the falling edge.
module tb_sfr_bus_arb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   got;
  int   wren_seen;

  sfr_bus_arb_if #(.ADDR_W(7), .DATA_W(8)) if0 ();
  sfr_bus_arb_if #(.ADDR_W(7), .DATA_W(8)) if1 ();

  sfr_bus_arb #(.ADDR_W(7), .DATA_W(8), .FIXED_PRIO(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sfr_bus_arb #(.ADDR_W(7), .DATA_W(8), .FIXED_PRIO(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic [1:0] op, input logic [6:0] addr, input logic [7:0] wd, input logic [2:0] b);
    if0.m0_op = op; if0.m0_addr = addr; if0.m0_wdata = wd; if0.m0_bit = b;
  endtask

  initial begin
    checks = 0; errors = 0;
    if0.m0_req = 0; if0.m0_op = 0; if0.m0_addr = 0; if0.m0_wdata = 0; if0.m0_bit = 0;
    if0.m1_req = 0; if0.m1_op = 0; if0.m1_addr = 0; if0.m1_wdata = 0; if0.m1_bit = 0;
    if0.sfr_q = 0;
    if1.m0_req = 0; if1.m0_op = 0; if1.m0_addr = 0; if1.m0_wdata = 0; if1.m0_bit = 0;
    if1.m1_req = 0; if1.m1_op = 0; if1.m1_addr = 0; if1.m1_wdata = 0; if1.m1_bit = 0;
    if1.sfr_q = 0;
    rst_n = 0;
    #12;
    chk("rst_busy", if0.busy, 0);
    chk("rst_rden", if0.sfr_rden, 0);
    chk("rst_wren", if0.sfr_wren, 0);
    chk("rst_addr", if0.sfr_address, 0);
    chk("rst_data", if0.sfr_data, 0);
    chk("rst_acks", {if0.m0_ack, if0.m1_ack}, 0);
    chk("rst_rdata", {if0.m0_rdata, if0.m1_rdata}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // m0 read 0x10 -> 0xA5
    set_m0(2'b00, 7'h10, 8'h00, 3'd0); if0.sfr_q = 8'hA5; if0.m0_req = 1;
    @(negedge clk);
    chk("rd_rden", if0.sfr_rden, 1);
    chk("rd_wren", if0.sfr_wren, 0);
    chk("rd_addr", if0.sfr_address, 7'h10);
    chk("rd_busy", if0.busy, 1);
    chk("rd_ack_early", if0.m0_ack, 0);
    @(negedge clk);
    chk("rd_ack", if0.m0_ack, 1);
    chk("rd_rden_off", if0.sfr_rden, 0);
    chk("rd_addr_off", if0.sfr_address, 0);
    chk("rd_rdata", if0.m0_rdata, 8'hA5);
    if0.m0_req = 0;
    @(negedge clk);
    chk("rd_idle", {if0.busy, if0.m0_ack}, 0);

    // m1 write 0x20 <- 0x3C
    if0.m1_op = 2'b01; if0.m1_addr = 7'h20; if0.m1_wdata = 8'h3C; if0.m1_req = 1;
    @(negedge clk);
    chk("wr_wren", if0.sfr_wren, 1);
    chk("wr_rden", if0.sfr_rden, 0);
    chk("wr_addr", if0.sfr_address, 7'h20);
    chk("wr_data", if0.sfr_data, 8'h3C);
    @(negedge clk);
    chk("wr_ack", {if0.m1_ack, if0.m0_ack}, 2'b10);
    chk("wr_strobes_off", {if0.sfr_wren, if0.sfr_rden, if0.sfr_data}, 0);
    chk("wr_m1_rdata", if0.m1_rdata, 8'h00);
    chk("wr_m0_rdata", if0.m0_rdata, 8'hA5);
    if0.m1_req = 0;
    @(negedge clk);

    // m0 bit-write: clear bit 3 of 0xFF -> 0xF7
    set_m0(2'b10, 7'h00, 8'h00, 3'd3); if0.sfr_q = 8'hFF; if0.m0_req = 1;
    @(negedge clk);
    chk("bw_rden", if0.sfr_rden, 1);
    chk("bw_addr", if0.sfr_address, 7'h00);
    @(negedge clk);
    chk("bw_wren", {if0.sfr_wren, if0.sfr_rden}, 2'b10);
    chk("bw_data", if0.sfr_data, 8'hF7);
    chk("bw_ack_early", if0.m0_ack, 0);
    @(negedge clk);
    chk("bw_ack", if0.m0_ack, 1);
    chk("bw_rdata", if0.m0_rdata, 8'hFF);
    if0.m0_req = 0;
    @(negedge clk);

    // m0 bit-toggle bit 7 of 0x0F -> 0x8F
    set_m0(2'b11, 7'h33, 8'h00, 3'd7); if0.sfr_q = 8'h0F; if0.m0_req = 1;
    @(negedge clk);
    chk("bt_rden", if0.sfr_rden, 1);
    @(negedge clk);
    chk("bt_data", if0.sfr_data, 8'h8F);
    chk("bt_addr", if0.sfr_address, 7'h33);
    @(negedge clk);
    chk("bt_ack", if0.m0_ack, 1);
    chk("bt_rdata", if0.m0_rdata, 8'h0F);
    if0.m0_req = 0;
    @(negedge clk);

    // round-robin: m0 was granted last, so m1 wins the first tie
    set_m0(2'b00, 7'h01, 8'h00, 3'd0); if0.m1_op = 2'b00; if0.m1_addr = 7'h02;
    if0.sfr_q = 8'h5A;
    if0.m0_req = 1; if0.m1_req = 1;
    for (int t = 0; t < 4; t++) begin
      got = 2;
      for (int c = 0; c < 6 && got == 2; c++) begin
        @(negedge clk);
        chk("rr_one_ack", {31'd0, if0.m0_ack & if0.m1_ack}, 0);
        if (if0.m0_ack) got = 0;
        else if (if0.m1_ack) got = 1;
      end
      chk($sformatf("rr_grant%0d", t), got, (t % 2 == 0) ? 1 : 0);
      if (t == 3) begin
        if0.m0_req = 0; if0.m1_req = 0;
      end else begin
        if (got == 0) if0.m0_req = 0;
        if (got == 1) if0.m1_req = 0;
        @(negedge clk);
        if0.m0_req = 1; if0.m1_req = 1;
      end
    end
    @(negedge clk);

    // fixed priority: m0 re-raised after each ack starves m1
    if1.sfr_q = 8'h11; if1.m0_req = 1; if1.m1_req = 1;
    for (int t = 0; t < 3; t++) begin
      got = 2;
      for (int c = 0; c < 6 && got == 2; c++) begin
        @(negedge clk);
        chk("fp_m1_starved", if1.m1_ack, 0);
        if (if1.m0_ack) got = 0;
        else if (if1.m1_ack) got = 1;
      end
      chk($sformatf("fp_grant%0d", t), got, 0);
      if (t == 2) begin
        if1.m0_req = 0; if1.m1_req = 0;
      end else begin
        if1.m0_req = 0;
        @(negedge clk);
        if1.m0_req = 1;
      end
    end
    @(negedge clk);

    // reset during RMW_RD abandons the write and issues no ack
    set_m0(2'b10, 7'h05, 8'h01, 3'd2); if0.sfr_q = 8'h00; if0.m0_req = 1;
    @(negedge clk);
    chk("mid_rden", if0.sfr_rden, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_strobes", {if0.sfr_rden, if0.sfr_wren}, 0);
    chk("mid_addr", if0.sfr_address, 0);
    chk("mid_busy", if0.busy, 0);
    if0.m0_req = 0;
    wren_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if0.sfr_wren || if0.m0_ack) wren_seen++;
    end
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if0.sfr_wren || if0.m0_ack) wren_seen++;
    end
    chk("mid_no_wren_ack", wren_seen, 0);
    set_m0(2'b00, 7'h06, 8'h00, 3'd0); if0.m1_op = 2'b00; if0.sfr_q = 8'h77;
    if0.m0_req = 1; if0.m1_req = 1;
    got = 2;
    for (int c = 0; c < 6 && got == 2; c++) begin
      @(negedge clk);
      if (if0.m0_ack) got = 0;
      else if (if0.m1_ack) got = 1;
    end
    chk("post_rst_tie", got, 0);
    chk("post_rst_rdata", if0.m0_rdata, 8'h77);
    if0.m0_req = 0; if0.m1_req = 0;
    @(negedge clk);

    // random traffic with protocol invariants
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      chk("inv_strobes", {31'd0, if0.sfr_rden & if0.sfr_wren}, 0);
      chk("inv_one_ack", {31'd0, if0.m0_ack & if0.m1_ack}, 0);
      if (if0.m0_ack || if0.m1_ack)
        chk("inv_ack_state", {if0.busy, if0.sfr_rden, if0.sfr_wren}, 3'b100);
      if (!if0.sfr_rden && !if0.sfr_wren)
        chk("inv_bus_quiet", {if0.sfr_address, if0.sfr_data}, 0);
      if0.sfr_q = 8'($urandom);
      if (if0.m0_ack) if0.m0_req = 0;
      else if (!if0.m0_req && $urandom_range(0, 1) == 1) begin
        set_m0(2'($urandom), 7'($urandom), 8'($urandom), 3'($urandom));
        if0.m0_req = 1;
      end
      if (if0.m1_ack) if0.m1_req = 0;
      else if (!if0.m1_req && $urandom_range(0, 1) == 1) begin
        if0.m1_op = 2'($urandom); if0.m1_addr = 7'($urandom);
        if0.m1_wdata = 8'($urandom); if0.m1_bit = 3'($urandom);
        if0.m1_req = 1;
      end
    end
    if0.m0_req = 0; if0.m1_req = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
